// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: recovers bytes from an asynchronous serial line and
// presents each correctly framed byte as a single-cycle strobe.
module uart_byte_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] byte_out,
   output logic       valid_out,
   output logic       frame_err,
   output logic       busy
);

   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [2:0]       idx_q;
   logic [7:0]       sh_q;
   logic [7:0]       byte_q;
   logic             valid_q;
   logic             ferr_q;
   logic             busy_q;
   logic             sync1_q;
   logic             sync2_q;
   logic             rx_s;

   // Synchronizer flops reset to the idle level so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
      end
   end

   assign rx_s  = sync2_q;
   assign cnt_d = cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_q <= START;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            START: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q <= '0;
                  idx_q <= '0;
                  if (!rx_s) begin
                     state_q <= DATA;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            DATA: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q       <= '0;
                  sh_q[idx_q] <= rx_s;
                  if (idx_q == 3'd7) begin
                     state_q <= STOP;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            // Leaving at mid-stop-bit lets a back-to-back start edge be caught without a gap.
            STOP: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     byte_q  <= sh_q;
                     valid_q <= 1'b1;
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= WAIT_HIGH;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            // A line held low after a bad stop bit must not decode as a stream of zero bytes.
            WAIT_HIGH: begin
               if (rx_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign byte_out  = byte_q;
   assign valid_out = valid_q;
   assign frame_err = ferr_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: one instance at 4 clocks per bit, one at
// the default 868, with pulse monitors and hand-computed expected bytes.
module tb_uart_byte_rx;

   localparam int CPB_A = 4;
   localparam int CPB_B = 868;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] byteA;
   logic       validA;
   logic       ferrA;
   logic       busyA;
   logic       rstB;
   logic       rxB;
   logic [7:0] byteB;
   logic       validB;
   logic       ferrB;
   logic       busyB;

   int checks = 0;
   int failures = 0;

   int validCountA = 0;
   int ferrCountA = 0;
   int overlapCountA = 0;
   int validCountB = 0;
   int ferrCountB = 0;
   logic [7:0] rxQueueA[$];
   logic [7:0] lastByteB = 8'h00;
   time dropTime = 0;
   time validTimeA = 0;
   time busyRiseA = 0;
   time busyFallA = 0;
   logic busyPrevA = 1'b0;

   always #5 clk = ~clk;

   uart_byte_rx #(.CLKS_PER_BIT(CPB_A)) dutA (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .byte_out  (byteA),
      .valid_out (validA),
      .frame_err (ferrA),
      .busy      (busyA)
   );

   uart_byte_rx dutB (
      .clk       (clk),
      .rst       (rstB),
      .rx        (rxB),
      .byte_out  (byteB),
      .valid_out (validB),
      .frame_err (ferrB),
      .busy      (busyB)
   );

   // Pulse monitors sample on the falling edge, away from the register updates.
   always @(negedge clk) begin
      if (validA) begin
         validCountA++;
         rxQueueA.push_back(byteA);
         validTimeA = $time;
      end
      if (ferrA) ferrCountA++;
      if (validA && ferrA) overlapCountA++;
      if (busyA && !busyPrevA) busyRiseA = $time;
      if (!busyA && busyPrevA) busyFallA = $time;
      busyPrevA = busyA;
      if (validB) begin
         validCountB++;
         lastByteB = byteB;
      end
      if (ferrB) ferrCountB++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic driveLine(input bit useB, input logic v);
      if (useB) rxB = v;
      else rx = v;
   endtask

   task automatic holdBit(input bit useB, input logic v, input int cycles);
      driveLine(useB, v);
      repeat (cycles) @(negedge clk);
   endtask

   // Sends one 8N1 frame; the line is left at the stop-bit level afterwards.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input bit useB, input int cpb);
      if (!useB) dropTime = $time;
      holdBit(useB, 1'b0, cpb);
      for (int i = 0; i < 8; i++) holdBit(useB, data[i], cpb);
      holdBit(useB, stopBit, cpb);
   endtask

   task automatic checkNextByte(input string tag, input logic [7:0] expected);
      logic [7:0] got;
      got = (rxQueueA.size() > 0) ? rxQueueA.pop_front() : 8'hxx;
      checkOutput(tag, {24'd0, got}, {24'd0, expected});
   endtask

   initial begin
      int baseValid;
      int baseFerr;
      logic anyBad;

      rst = 1'b0;
      rx = 1'b1;
      rstB = 1'b0;
      rxB = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_byte", {24'd0, byteA}, 32'h0);
      checkOutput("reset_pulses_busy", {29'd0, validA, ferrA, busyA}, 32'h0);

      rst = 1'b1;
      rstB = 1'b1;
      anyBad = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (byteA != 8'h00 || validA || ferrA || busyA) anyBad = 1'b1;
      end
      checkOutput("idle_quiet", {31'd0, anyBad}, 32'h0);
      checkOutput("idle_no_valid", validCountA, 32'd0);

      applyStimulus(8'hE5, 1'b1, 1'b0, CPB_A);
      holdBit(1'b0, 1'b1, 8);
      checkOutput("e5_count", validCountA, 32'd1);
      checkNextByte("e5_value", 8'hE5);
      checkOutput("e5_valid_time", 32'(validTimeA - dropTime), 32'd410);
      checkOutput("e5_busy_rise", 32'(busyRiseA - dropTime), 32'd30);
      checkOutput("e5_busy_fall", 32'(busyFallA - dropTime), 32'd410);
      checkOutput("e5_byte_held", {24'd0, byteA}, 32'hE5);

      baseValid = validCountA;
      applyStimulus(8'h00, 1'b1, 1'b0, CPB_A);
      applyStimulus(8'hFF, 1'b1, 1'b0, CPB_A);
      applyStimulus(8'h2A, 1'b1, 1'b0, CPB_A);
      holdBit(1'b0, 1'b1, 8);
      checkOutput("b2b_count", validCountA - baseValid, 32'd3);
      checkNextByte("b2b_first", 8'h00);
      checkNextByte("b2b_second", 8'hFF);
      checkNextByte("b2b_third", 8'h2A);
      checkOutput("b2b_no_ferr", ferrCountA, 32'd0);

      baseValid = validCountA;
      holdBit(1'b0, 1'b0, 1);
      holdBit(1'b0, 1'b1, 10);
      checkOutput("glitch_no_valid", validCountA - baseValid, 32'd0);
      checkOutput("glitch_no_ferr", ferrCountA, 32'd0);
      checkOutput("glitch_idle", {31'd0, busyA}, 32'h0);
      applyStimulus(8'h81, 1'b1, 1'b0, CPB_A);
      holdBit(1'b0, 1'b1, 8);
      checkOutput("glitch_then_count", validCountA - baseValid, 32'd1);
      checkNextByte("glitch_then_value", 8'h81);

      baseValid = validCountA;
      baseFerr = ferrCountA;
      applyStimulus(8'h55, 1'b0, 1'b0, CPB_A);
      holdBit(1'b0, 1'b0, 20);
      checkOutput("ferr_waits_high", {31'd0, busyA}, 32'h1);
      holdBit(1'b0, 1'b1, 8);
      checkOutput("ferr_count", ferrCountA - baseFerr, 32'd1);
      checkOutput("ferr_no_valid", validCountA - baseValid, 32'd0);
      checkOutput("ferr_byte_kept", {24'd0, byteA}, 32'h81);
      applyStimulus(8'h3C, 1'b1, 1'b0, CPB_A);
      holdBit(1'b0, 1'b1, 8);
      checkOutput("ferr_then_count", validCountA - baseValid, 32'd1);
      checkNextByte("ferr_then_value", 8'h3C);
      checkOutput("no_overlap", overlapCountA, 32'd0);

      // Partial 0xA7 frame: start, bits 0..3, then halfway into bit 4.
      baseValid = validCountA;
      holdBit(1'b0, 1'b0, CPB_A);
      for (int i = 0; i < 4; i++) holdBit(1'b0, 1'(8'hA7 >> i), CPB_A);
      holdBit(1'b0, 1'b0, CPB_A / 2);
      checkOutput("rst_mid_busy_before", {31'd0, busyA}, 32'h1);
      rst = 1'b0;
      rx = 1'b1;
      #1;
      checkOutput("rst_mid_byte", {24'd0, byteA}, 32'h0);
      checkOutput("rst_mid_flags", {29'd0, validA, ferrA, busyA}, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      holdBit(1'b0, 1'b1, 8);
      applyStimulus(8'h12, 1'b1, 1'b0, CPB_A);
      holdBit(1'b0, 1'b1, 8);
      checkOutput("rst_mid_after_count", validCountA - baseValid, 32'd1);
      checkNextByte("rst_mid_after_value", 8'h12);

      holdBit(1'b1, 1'b1, 10);
      holdBit(1'b1, 1'b0, CPB_B);
      for (int i = 0; i < 4; i++) holdBit(1'b1, 1'(8'hA7 >> i), CPB_B);
      holdBit(1'b1, 1'b0, CPB_B / 2);
      checkOutput("slow_busy_before", {31'd0, busyB}, 32'h1);
      rstB = 1'b0;
      rxB = 1'b1;
      #1;
      checkOutput("slow_rst_clears", {23'd0, byteB, validB, ferrB, busyB}, 32'h0);
      repeat (3) @(negedge clk);
      rstB = 1'b1;
      holdBit(1'b1, 1'b1, 20);
      applyStimulus(8'h12, 1'b1, 1'b1, CPB_B);
      holdBit(1'b1, 1'b1, CPB_B);
      checkOutput("slow_count", validCountB, 32'd1);
      checkOutput("slow_value", {24'd0, lastByteB}, 32'h12);
      checkOutput("slow_no_ferr", ferrCountB, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
